menu_ctrl: RTL

//  Keyboard-driven menu/game-flow controller.
//  - Consumes decoded PS2 key events.
//  - Produces the level and map selection codes that the display address generator reads:

---
 rtl/menu_ctrl.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/menu_ctrl.sv
// Keyboard-driven menu / game-flow controller: MENU -> LAUNCH -> PLAY -> RESULT -> MENU.
// Optional held-key cursor repeat in MENU is built when MENU_AUTOREPEAT_EN is defined.
module menu_ctrl #(
    parameter int unsigned NUM_ITEMS     = 5,
    parameter int unsigned RESULT_CYCLES = 100_000_000,
    parameter int unsigned REPEAT_CYCLES = 25_000_000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_valid,
    input  logic [8:0] key_code,
    input  logic       key_make,
    input  logic       level_clear,
    output logic [2:0] level,
    output logic [2:0] map,
    output logic       start,
    output logic [1:0] state_o
);

    localparam logic [1:0] S_MENU   = 2'd0;
    localparam logic [1:0] S_LAUNCH = 2'd1;
    localparam logic [1:0] S_PLAY   = 2'd2;
    localparam logic [1:0] S_RESULT = 2'd3;

    localparam logic [8:0] KEY_UP    = 9'h175;
    localparam logic [8:0] KEY_DOWN  = 9'h172;
    localparam logic [8:0] KEY_ENTER = 9'h05A;
    localparam logic [8:0] KEY_ESC   = 9'h076;

    localparam logic [2:0] LAST_ITEM = 3'(NUM_ITEMS - 1);

    if (NUM_ITEMS < 1 || NUM_ITEMS > 7 || RESULT_CYCLES < 1 || REPEAT_CYCLES < 1) begin : g_param_check
        $error("menu_ctrl: parameter out of range");
    end

    logic [1:0]  state;
    logic        up_held, down_held, enter_held;
    logic [31:0] result_cnt;

    logic        is_up, is_down, is_enter, is_esc;
    logic        up_press, down_press, enter_press, esc_press;
    logic        up_rel, down_rel, enter_rel;
    logic [2:0]  map_dec, map_inc;
    logic        rep_up, rep_down;

    assign state_o = state;

    // A make only counts when the key is not already held, which drops typematic repeats.
    always_comb begin
        is_up       = key_valid && (key_code == KEY_UP);
        is_down     = key_valid && (key_code == KEY_DOWN);
        is_enter    = key_valid && (key_code == KEY_ENTER);
        is_esc      = key_valid && (key_code == KEY_ESC);
        up_press    = is_up    && key_make && !up_held;
        down_press  = is_down  && key_make && !down_held;
        enter_press = is_enter && key_make && !enter_held;
        esc_press   = is_esc   && key_make;
        up_rel      = is_up    && !key_make;
        down_rel    = is_down  && !key_make;
        enter_rel   = is_enter && !key_make;
        map_dec     = (map == 3'd0) ? LAST_ITEM : map - 3'd1;
        map_inc     = (map == LAST_ITEM) ? 3'd0 : map + 3'd1;
    end

`ifdef MENU_AUTOREPEAT_EN
    logic [31:0] rep_cnt;
    logic        rep_evt;
    logic        rep_fire;

    // Any up/down/enter event owns the cycle; the repeat step only fires on quiet cycles.
    always_comb begin
        rep_evt  = up_press || down_press || up_rel || down_rel || enter_press;
        rep_fire = (state == S_MENU) && !rep_evt && (up_held ^ down_held)
                   && (rep_cnt == REPEAT_CYCLES - 1);
        rep_up   = rep_fire && up_held;
        rep_down = rep_fire && down_held;
    end

    always_ff @(posedge clk) begin
        if (rst || state != S_MENU || rep_evt || !(up_held ^ down_held) || rep_fire) begin
            rep_cnt <= 32'd0;
        end else begin
            rep_cnt <= rep_cnt + 32'd1;
        end
    end
`else
    assign rep_up   = 1'b0;
    assign rep_down = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_MENU;
            level      <= 3'd0;
            map        <= 3'd0;
            start      <= 1'b0;
            up_held    <= 1'b0;
            down_held  <= 1'b0;
            enter_held <= 1'b0;
            result_cnt <= 32'd0;
        end else begin
            start <= 1'b0;
            if (is_up)    up_held    <= key_make;
            if (is_down)  down_held  <= key_make;
            if (is_enter) enter_held <= key_make;

            case (state)
                S_MENU: begin
                    if (enter_press) begin
                        state <= S_LAUNCH;
                        level <= map + 3'd1;
                    end else if (up_press || rep_up) begin
                        map <= map_dec;
                    end else if (down_press || rep_down) begin
                        map <= map_inc;
                    end
                end
                S_LAUNCH: begin
                    if (esc_press) begin
                        state <= S_MENU;
                        level <= 3'd0;
                    end else if (enter_rel) begin
                        state <= S_PLAY;
                        start <= 1'b1;
                    end
                end
                S_PLAY: begin
                    if (level_clear) begin
                        state      <= S_RESULT;
                        result_cnt <= RESULT_CYCLES - 1;
                    end else if (esc_press) begin
                        state <= S_MENU;
                        level <= 3'd0;
                    end
                end
                default: begin
                    // Timeout preselects the next stage; esc returns without advancing.
                    if (esc_press) begin
                        state      <= S_MENU;
                        level      <= 3'd0;
                        result_cnt <= 32'd0;
                    end else if (result_cnt == 32'd0) begin
                        state <= S_MENU;
                        level <= 3'd0;
                        map   <= map_inc;
                    end else begin
                        result_cnt <= result_cnt - 32'd1;
                    end
                end
            endcase
        end
    end

endmodule
